// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR ADC controller.
// State encoding plus bit-period and counter-width math.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } state_e;

  // Cycles spent on one bit: trial drive, settling, synchronizer.
  function automatic int t_bit(input int settle, input int sync);
    return 1 + settle + sync;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sar_cmp_sync.sv
// Multi-flop synchronizer for the asynchronous comparator output.
// Clears to 0 on reset so the first decision is never X.
module sar_cmp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // Shift the comparator level through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: sample, resolve MSB first,
// then present the word with a one-cycle done strobe.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data
);

  localparam int TBIT  = t_bit(SETTLE_CYCLES, SYNC_STAGES);
  localparam int CNT_W =
    max2(1, clog2(max2(SAMPLE_CYCLES, TBIT)));
  localparam int IDX_W = max2(1, clog2(WIDTH));

  localparam logic [CNT_W-1:0] SAMP_LD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LD  = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             sample_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] code_q;
  logic [WIDTH-1:0] data_q;

  logic             cmp_s;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] trial_d;

  sar_cmp_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (cmp_in),
    .q_o  (cmp_s)
  );

  // Resolve the current bit and form the next trial code.
  always_comb begin
    mask    = ONE << idx_q;
    res_d   = cmp_s ? code_q : (code_q & ~mask);
    trial_d = res_d | (mask >> 1);
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= '0;
      data_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= SAMPLE;
            cnt_q    <= SAMP_LD;
            sample_q <= 1'b1;
            busy_q   <= 1'b1;
            code_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state_q  <= IDLE;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            code_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q  <= CONVERT;
            sample_q <= 1'b0;
            cnt_q    <= BIT_LD;
            idx_q    <= IDX_MSB;
            code_q   <= ONE << IDX_MSB;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        CONVERT: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            code_q  <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (idx_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            data_q  <= res_d;
            code_q  <= '0;
          end else begin
            code_q <= trial_d;
            idx_q  <= idx_q - IDX_ONE;
            cnt_q  <= BIT_LD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample   = sample_q;
  assign dac_code = code_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data     = data_q;

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Successive-approximation controller that sits directly downstream of the ADC comparator and consumes its VOUT.
- Drives the sample/hold switch and the capacitive/resistive DAC code.
- Resolves one bit per bit-period, MSB first.
- Presents the converted word with a one-cycle done strobe to the bus-side wrapper.
- The comparator's VINP is the held input and VINM is the DAC output, so cmp_in=1 means input > DAC.

Parameters:
WIDTH, 10, conversion resolution in bits (legal range 2..16)
SAMPLE_CYCLES, 4, cycles the sample output is held high (>=1)
SETTLE_CYCLES, 1, DAC settling cycles per bit before the comparator is read (>=0)
SYNC_STAGES, 2, flops in the cmp_in synchronizer (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only in IDLE or in the done cycle
abort  input  1  synchronous abort of an in-flight conversion
cmp_in  input  1  comparator VOUT, asynchronous to clk
sample  output  1  high while the S/H tracks the input
dac_code  output  WIDTH  trial code to the DAC
busy  output  1  conversion in progress
done  output  1  one-cycle pulse, data valid
data  output  WIDTH  last completed result, held until the next completion

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous active-low; all flops clear immediately on assertion.
- Reset values: sample=0, dac_code=0, busy=0, done=0, data=0, state=IDLE, synchronizer flops=0.
- States: IDLE -> SAMPLE -> CONVERT -> DONE -> IDLE.
- Bit period: T_BIT = 1 + SETTLE_CYCLES + SYNC_STAGES.
- Timing, with cycle 0 the cycle where start=1 is sampled in IDLE:
  - SAMPLE occupies cycles 1..SAMPLE_CYCLES. sample=1, dac_code=0, busy=1.
  - CONVERT: bit i (WIDTH-1 down to 0) uses T_BIT cycles. First cycle: dac_code = resolved bits | (1<<i). In the last cycle, synchronized cmp: 1 keeps bit i, 0 clears it. The decision is visible in dac_code from the next cycle.
  - DONE is the single cycle N = SAMPLE_CYCLES + WIDTH*T_BIT + 1. done=1, busy=0, data=final code, dac_code returns to 0. The state then goes to IDLE.
  - Defaults: N = 4 + 10*4 + 1 = 45.
- Counters:
  - A cycle counter of width clog2(max(SAMPLE_CYCLES, T_BIT)) reloads at each phase or bit boundary.
  - A bit index counter counts down from WIDTH-1. It does not wrap; the decision at index 0 ends CONVERT.
- start while busy: ignored, no queuing.
- start=1 in the DONE cycle: accepted, and SAMPLE begins the next cycle (back-to-back conversions).
- abort=1 while busy: next cycle returns to IDLE with sample=0, dac_code=0, busy=0. No done pulse; data unchanged.
- abort in IDLE or DONE: no effect. If start and abort are both high in IDLE, start wins.
- rst_n asserted mid-conversion: immediate return to reset values. No done pulse and no partial data.
- cmp_in is only consumed through the synchronizer. Values outside each bit's decision cycle are don't-care.
- data changes only in the DONE cycle.

Decomposition:
- Package sar_pkg:
  - state enum {IDLE, SAMPLE, CONVERT, DONE}
  - function computing T_BIT
  - clog2 helper for counter widths
- Sub-module sar_cmp_sync: SYNC_STAGES-deep flop chain on cmp_in, async reset to 0, with the same clk/rst_n naming.
- Everything else lives in the single FSM/datapath in sar_adc_ctrl.

Test Plan:
Bench comparator model: cmp_in = (2*vin_code+1 > 2*dac_code), updated combinationally from dac_code. Defaults for all parameters.
- vin_code=600, pulse start -> done at cycle 45 after start, data=600 (0x258), busy high cycles 1..44, sample high cycles 1..4.
- vin_code=0 then vin_code=1023, consecutive conversions -> data=0 then data=1023. Check the trial dac_code sequence 512, 256, 128, ... for vin=0.
- start held high continuously with vin_code=341 -> conversions back-to-back, done every 45 cycles, each data=341, no idle gap.
- abort at cycle 20 of a vin_code=777 conversion after a prior result of 600 -> busy drops at cycle 21, no done, data stays 600; next start yields 777.
- rst_n low at cycle 30 mid-conversion -> all outputs 0 immediately. After release, start with vin_code=5 -> data=5 at cycle 45.
- cmp_in toggled randomly outside decision cycles, plus start pulses while busy -> result unaffected, extra starts ignored, exactly one done per accepted start.
